// File: rtl/iord_pkg.sv
// Shared encodings for the memory address-port scheduler: IorD selects, exception
// causes, requester ids and FSM states.
package iord_pkg;

   localparam logic [2:0] IORD_PC      = 3'b000;
   localparam logic [2:0] IORD_ALU     = 3'b001;
   localparam logic [2:0] IORD_EXC_OPC = 3'b010;
   localparam logic [2:0] IORD_EXC_OVF = 3'b011;
   localparam logic [2:0] IORD_EXC_DIV = 3'b100;

   localparam logic [1:0] CAUSE_OPC = 2'b00;
   localparam logic [1:0] CAUSE_OVF = 2'b01;
   localparam logic [1:0] CAUSE_DIV = 2'b10;
   localparam logic [1:0] CAUSE_RSV = 2'b11;

   localparam logic [1:0] RID_FETCH = 2'd0;
   localparam logic [1:0] RID_DATA  = 2'd1;
   localparam logic [1:0] RID_EXC   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } iord_state_e;

   // The reserved cause falls back to the bad-opcode vector.
   function automatic logic [2:0] exc_vec_sel(input logic [1:0] cause);
      case (cause)
         CAUSE_OVF: return IORD_EXC_OVF;
         CAUSE_DIV: return IORD_EXC_DIV;
         default:   return IORD_EXC_OPC;
      endcase
   endfunction

endpackage

// File: rtl/iord_lat_counter.sv
// Memory-latency counter: counts 0..MEM_LAT-1 while enabled, flags the last count,
// and is cleared back to zero while the scheduler waits for a grant.
module iord_lat_counter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam int unsigned   CW     = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = tc_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iord_access_sched.sv
// Arbitrates the shared memory address port (exc > data > fetch), holds the IorD select
// for MEM_LAT cycles, then pulses the grantee's ack; every output is a register.
module iord_access_sched
   import iord_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fetch_req,
   input  logic       data_req,
   input  logic       data_we,
   input  logic       exc_req,
   input  logic [1:0] exc_cause,
   output logic [2:0] iord_sel,
   output logic       mem_wr,
   output logic       fetch_ack,
   output logic       data_ack,
   output logic       exc_ack,
   output logic       busy
);

   iord_state_e state_q, state_d;
   logic [1:0]  rid_q, rid_d;
   logic [2:0]  sel_q, sel_d;
   logic        wr_q, wr_d;
   logic        fack_q, fack_d;
   logic        dack_q, dack_d;
   logic        eack_q, eack_d;
   logic        busy_q, busy_d;
   logic        cnt_clr, cnt_en, cnt_tc;

   iord_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (cnt_clr),
      .enable_i (cnt_en),
      .tc_o     (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      rid_d   = rid_q;
      sel_d   = sel_q;
      wr_d    = wr_q;
      fack_d  = 1'b0;
      dack_d  = 1'b0;
      eack_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sel_d   = IORD_PC;
            wr_d    = 1'b0;
            cnt_clr = 1'b1;
            // Grant-time sampling: the select and write strobe are fixed here for the whole access.
            if (exc_req) begin
               state_d = ST_ACCESS;
               rid_d   = RID_EXC;
               sel_d   = exc_vec_sel(exc_cause);
            end else if (data_req) begin
               state_d = ST_ACCESS;
               rid_d   = RID_DATA;
               sel_d   = IORD_ALU;
               wr_d    = data_we;
            end else if (fetch_req) begin
               state_d = ST_ACCESS;
               rid_d   = RID_FETCH;
            end
         end
         ST_ACCESS: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               state_d = ST_DONE;
               wr_d    = 1'b0;
               fack_d  = (rid_q == RID_FETCH);
               dack_d  = (rid_q == RID_DATA);
               eack_d  = (rid_q == RID_EXC);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = IORD_PC;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = IORD_PC;
            wr_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         rid_q   <= RID_FETCH;
         sel_q   <= IORD_PC;
         wr_q    <= 1'b0;
         fack_q  <= 1'b0;
         dack_q  <= 1'b0;
         eack_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rid_q   <= rid_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
         fack_q  <= fack_d;
         dack_q  <= dack_d;
         eack_q  <= eack_d;
         busy_q  <= busy_d;
      end
   end

   assign iord_sel  = sel_q;
   assign mem_wr    = wr_q;
   assign fetch_ack = fack_q;
   assign data_ack  = dack_q;
   assign exc_ack   = eack_q;
   assign busy      = busy_q;

endmodule
